// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: everything vga_timing_gen drives toward the
// line-buffer fetch engine and the HDMI encoder.
// The frame_cnt signal exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          hs;
  logic          vs;
  logic          active_nblank;
  logic          v_blank;
  logic          frame_start;
  logic          fetch_line;
  logic [CW-1:0] fetch_y;
  logic [CW-1:0] drawX;
  logic [CW-1:0] drawY;
  logic [CW-1:0] srcX;
  logic [CW-1:0] srcY;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  modport master (
    output hs, vs, active_nblank, v_blank, frame_start, fetch_line,
    output fetch_y, drawX, drawY, srcX, srcY
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input hs, vs, active_nblank, v_blank, frame_start, fetch_line,
    input fetch_y, drawX, drawY, srcX, srcY
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with integer pixel/line replication.
// Every output is a register loaded from the *next* raster position, so all
// outputs describe the same (drawX, drawY) in the same cycle.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FETCH_X    = 640,
  parameter int SCALE_LOG2 = 0,
  parameter int CW         = 10
) (
  input  logic             pixel_clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FX     = CW'(FETCH_X);
  localparam logic [CW-1:0] S_MASK = CW'((1 << SCALE_LOG2) - 1);

  // Region bounds held in 32 bits so an end bound equal to 2^CW cannot wrap.
  localparam logic [31:0] HA     = 32'(H_ACTIVE);
  localparam logic [31:0] VA     = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] nx, ny, nny;
  logic          hs_on, vs_on;

  // Next raster position and the line following it (for prefetch).
  always_comb begin
    nx  = (bus.drawX == H_LAST) ? '0 : bus.drawX + CW'(1);
    ny  = bus.drawY;
    if (bus.drawX == H_LAST)
      ny = (bus.drawY == V_LAST) ? '0 : bus.drawY + CW'(1);
    nny = (ny == V_LAST) ? '0 : ny + CW'(1);
    hs_on = (32'(nx) >= HS_BEG) && (32'(nx) < HS_END);
    vs_on = (32'(ny) >= VS_BEG) && (32'(ny) < VS_END);
  end

  // Output registers: reset parks at the last position of the frame so the
  // first released edge lands on (0,0).
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      bus.drawX         <= H_LAST;
      bus.drawY         <= V_LAST;
      bus.srcX          <= H_LAST >> SCALE_LOG2;
      bus.srcY          <= V_LAST >> SCALE_LOG2;
      bus.hs            <= ~HS_POL;
      bus.vs            <= ~VS_POL;
      bus.active_nblank <= 1'b0;
      bus.v_blank       <= 1'b1;
      bus.frame_start   <= 1'b0;
      bus.fetch_line    <= 1'b0;
      bus.fetch_y       <= '0;
    end else begin
      bus.drawX         <= nx;
      bus.drawY         <= ny;
      bus.srcX          <= nx >> SCALE_LOG2;
      bus.srcY          <= ny >> SCALE_LOG2;
      bus.hs            <= hs_on ? HS_POL : ~HS_POL;
      bus.vs            <= vs_on ? VS_POL : ~VS_POL;
      bus.active_nblank <= (32'(nx) < HA) && (32'(ny) < VA);
      bus.v_blank       <= (32'(ny) >= VA);
      bus.frame_start   <= (nx == '0) && (ny == '0);
      bus.fetch_line    <= (nx == FX) && (32'(nny) < VA) && ((nny & S_MASK) == '0);
      bus.fetch_y       <= nny >> SCALE_LOG2;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge pixel_clk) begin
    if (!reset)
      bus.frame_cnt <= '0;
    else if ((nx == '0) && (ny == '0))
      bus.frame_cnt <= bus.frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset bench for vga_timing_gen: four parameter sets side by
// side, each compared every cycle against a position derived from elapsed
// cycles since reset release.
module tb_vga_timing_gen;
  logic pixel_clk = 1'b0;
  logic reset     = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected output word: {10'b0, hs, vs, act, vblank, fs, fl, fetch_y, x, y, sx, sy}
  function automatic logic [95:0] ref_vec(input int ha, hf, hw, hb, va, vf, vw, vb,
                                          input int hp, vp, fx, sl,
                                          input bit rs, input int t);
    int ht, vt, p, x, y, nyy, fy;
    logic hs, vs, an, vbk, fs, fl;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (rs) begin
      x = ht - 1; y = vt - 1;
    end else begin
      p = t % (ht * vt);
      x = p % ht; y = p / ht;
    end
    nyy = (y + 1) % vt;
    hs  = (x >= ha + hf && x < ha + hf + hw) ? hp[0] : !hp[0];
    vs  = (y >= va + vf && y < va + vf + vw) ? vp[0] : !vp[0];
    if (rs) begin hs = !hp[0]; vs = !vp[0]; end
    an  = !rs && x < ha && y < va;
    vbk = rs || y >= va;
    fs  = !rs && x == 0 && y == 0;
    fl  = !rs && x == fx && nyy < va && (nyy % (1 << sl)) == 0;
    fy  = rs ? 0 : nyy >> sl;
    return {10'b0, hs, vs, an, vbk, fs, fl, 16'(fy), 16'(x), 16'(y), 16'(x >> sl), 16'(y >> sl)};
  endfunction

  vga_timing_gen_if #(.CW(10)) bus_d ();
  vga_timing_gen_if #(.CW(5))  bus_a ();
  vga_timing_gen_if #(.CW(5))  bus_b ();
  vga_timing_gen_if #(.CW(5))  bus_c ();

  vga_timing_gen u_d (.pixel_clk(pixel_clk), .reset(reset), .bus(bus_d));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_X(16), .SCALE_LOG2(0), .CW(5)
  ) u_a (.pixel_clk(pixel_clk), .reset(reset), .bus(bus_a));

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_X(20), .SCALE_LOG2(1), .CW(5)
  ) u_b (.pixel_clk(pixel_clk), .reset(reset), .bus(bus_b));

  vga_timing_gen #(
    .H_ACTIVE(24), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .FETCH_X(31), .SCALE_LOG2(2), .CW(5)
  ) u_c (.pixel_clk(pixel_clk), .reset(reset), .bus(bus_c));

  localparam int NCYC = 12000;

  initial begin
    bit   rs = 1'b1;
    int   t = 0;
    int   hold = 0;
    int   last_fs = 0;
    bit   fs_ok = 1'b0;
    int   fl_b = 0, fl_c = 0;
    bit   win_b = 1'b0, win_c = 1'b0;
    logic [95:0] ea;
`ifdef VGA_TIMING_FRAME_CNT_EN
    int   fc = 0;
`endif
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge pixel_clk);
      if (!reset) begin
        rs = 1'b1; t = 0;
      end else begin
        t = rs ? 0 : t + 1;
        rs = 1'b0;
      end
      ea = ref_vec(16, 3, 4, 5, 12, 2, 2, 3, 0, 0, 16, 0, rs, t);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (rs) fc = 0;
      else if (ea[81]) fc = (fc + 1) % 65536;
`endif
      @(negedge pixel_clk);

      check("d_out", {10'b0, bus_d.hs, bus_d.vs, bus_d.active_nblank, bus_d.v_blank,
            bus_d.frame_start, bus_d.fetch_line, 16'(bus_d.fetch_y), 16'(bus_d.drawX),
            16'(bus_d.drawY), 16'(bus_d.srcX), 16'(bus_d.srcY)},
            ref_vec(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 640, 0, rs, t));
      check("a_out", {10'b0, bus_a.hs, bus_a.vs, bus_a.active_nblank, bus_a.v_blank,
            bus_a.frame_start, bus_a.fetch_line, 16'(bus_a.fetch_y), 16'(bus_a.drawX),
            16'(bus_a.drawY), 16'(bus_a.srcX), 16'(bus_a.srcY)}, ea);
      check("b_out", {10'b0, bus_b.hs, bus_b.vs, bus_b.active_nblank, bus_b.v_blank,
            bus_b.frame_start, bus_b.fetch_line, 16'(bus_b.fetch_y), 16'(bus_b.drawX),
            16'(bus_b.drawY), 16'(bus_b.srcX), 16'(bus_b.srcY)},
            ref_vec(20, 2, 3, 3, 10, 1, 2, 2, 1, 1, 20, 1, rs, t));
      check("c_out", {10'b0, bus_c.hs, bus_c.vs, bus_c.active_nblank, bus_c.v_blank,
            bus_c.frame_start, bus_c.fetch_line, 16'(bus_c.fetch_y), 16'(bus_c.drawX),
            16'(bus_c.drawY), 16'(bus_c.srcX), 16'(bus_c.srcY)},
            ref_vec(24, 2, 3, 3, 12, 1, 2, 1, 1, 0, 31, 2, rs, t));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("a_frame_cnt", 96'(bus_a.frame_cnt), 96'(fc));
`endif

      // Frame period and per-frame prefetch counts over uninterrupted frames.
      if (rs) begin
        fs_ok = 1'b0; win_b = 1'b0; win_c = 1'b0;
      end else begin
        if (bus_a.frame_start) begin
          if (fs_ok) check("a_period", 96'(cyc - last_fs), 96'(28 * 19));
          last_fs = cyc; fs_ok = 1'b1;
        end
        if (bus_b.frame_start) begin
          if (win_b) check("b_fetch_cnt", 96'(fl_b), 96'(5));
          fl_b = 0; win_b = 1'b1;
        end
        if (bus_c.frame_start) begin
          if (win_c) check("c_fetch_cnt", 96'(fl_c), 96'(3));
          fl_c = 0; win_c = 1'b1;
        end
        if (bus_b.fetch_line) fl_b++;
        if (bus_c.fetch_line) fl_c++;
      end

      // Reset stimulus for the next edge: power-on, a 3-cycle mid-frame
      // pulse, then sparse random pulses of 1..4 cycles.
      if (cyc < 2) begin
        reset = 1'b0;
      end else if (hold > 0) begin
        reset = 1'b0; hold--;
      end else if (cyc == 2600) begin
        reset = 1'b0; hold = 2;
      end else if (cyc > 4000 && $urandom_range(0, 999) == 0) begin
        reset = 1'b0; hold = int'($urandom_range(0, 3));
      end else begin
        reset = 1'b1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the pixel pipeline, replacing the fixed 640x480 controller. Produces horizontal/vertical counters, programmable-polarity sync, active-video flag, vertical-blank flag, a frame-start pulse, and a line-prefetch pulse for the line buffer. Supports integer pixel/line replication (SCALE) so a low-resolution framebuffer can drive a full-resolution raster. Sits between the pixel clock domain and the line-buffer fetch engine / HDMI encoder.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs
- FETCH_X, 640, horizontal position at which fetch_line fires (0..H_TOTAL-1)
- SCALE_LOG2, 0, replication factor 2^SCALE_LOG2 (0..2)
- CW, 10, counter width; H_TOTAL and V_TOTAL must be ≤ 2^CW
- pixel_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- hs  out  1  horizontal sync, polarity HS_POL
- vs  out  1  vertical sync, polarity VS_POL
- active_nblank  out  1  high when in visible region
- v_blank  out  1  high when drawY ≥ V_ACTIVE
- frame_start  out  1  one-cycle pulse at position (0,0)
- fetch_line  out  1  one-cycle pulse requesting the next source line
- fetch_y  out  CW  source line index for the fetch_line request
- drawX, drawY  out  CW each  current raster position
- srcX, srcY  out  CW each  drawX >> SCALE_LOG2, drawY >> SCALE_LOG2

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults: 800 x 525.
- hc increments every cycle, wraps H_TOTAL-1 → 0; vc increments on hc wrap, wraps V_TOTAL-1 → 0.
- All outputs are registered and describe the same (drawX, drawY) position in the same cycle; no output lags another.
- hs asserted iff H_ACTIVE+H_FP ≤ drawX < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vs asserted iff V_ACTIVE+V_FP ≤ drawY < V_ACTIVE+V_FP+V_SYNC (default 490..491), full lines.
- active_nblank = (drawX < H_ACTIVE) && (drawY < V_ACTIVE).
- frame_start = 1 iff position is (0,0).
- next_y = (drawY == V_TOTAL-1) ? 0 : drawY+1. fetch_line = 1 iff drawX == FETCH_X, next_y < V_ACTIVE, and next_y low SCALE_LOG2 bits are zero; fetch_y = next_y >> SCALE_LOG2. Defaults: fires on lines 524 and 0..478 (480 pulses/frame).
- With SCALE_LOG2 = 1: 240 pulses/frame, on lines 524, 1, 3, …, 477.
- Reset (reset low at an edge): position loads (H_TOTAL-1, V_TOTAL-1); hs, vs deasserted (~HS_POL, ~VS_POL); active_nblank 0; v_blank 1; frame_start, fetch_line 0; fetch_y 0. Reset mid-frame aborts the frame immediately, same values.

## Timing
- First rising edge with reset high: position becomes (0,0), frame_start = 1, active_nblank = 1.
- Frame period H_TOTAL·V_TOTAL cycles (default 420000); frame_start exactly once per period.
- fetch_line leads the first pixel of its target line by H_TOTAL−FETCH_X cycles (default 160).
- No handshake; fetch_line is fire-and-forget, consumer must accept within one line.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: adds output frame_cnt (16 bits), reset to 0, increments on the same edge frame_start asserts (first frame after reset reads 1), wraps 65535 → 0.
- Undefined: port absent; no counter logic.

## Test plan
- Default params, release reset → drawX/drawY = (0,0) and frame_start = 1 on first edge; next frame_start exactly 420000 cycles later.
- Sweep one frame → hs low for drawX 656..751 only, vs low for drawY 490..491 only, active_nblank high for exactly 307200 cycles.
- Count fetch_line per frame → 480 pulses, all at drawX = 640; first at drawY = 524 with fetch_y = 0, last at drawY = 478 with fetch_y = 479.
- SCALE_LOG2 = 1 → 240 pulses, fetch_y 0..239; srcX = 319 when drawX = 639.
- Assert reset at (300,200) for 3 cycles → outputs hold reset values; first edge after release gives (0,0), frame_start = 1.
- HS_POL = 1, VS_POL = 1, 800x600 timing (40/128/88, 1/4/23) → hs high drawX 840..967, vs high drawY 601..604, period 1056·628 cycles; with VGA_TIMING_FRAME_CNT_EN, frame_cnt = 3 at third frame_start.
